periph_bridge: RTL and testbench
================================

PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter CLINT_BASE, default 32'h0200_0000, base of the 64 KB CLINT window.
REQ-002 SHALL have parameter UART_BASE, default 32'h1000_0000, base of the 4 KB UART window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles to wait for target ready.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_req_valid  input  1  CPU request valid.
REQ-007 SHALL have port cpu_req_ready  output  1  bridge accepts request this cycle.
REQ-008 SHALL have port cpu_req_addr  input  32  byte address.
REQ-009 SHALL have port cpu_req_we  input  1  1=write, 0=read.
REQ-010 SHALL have port cpu_req_wdata  input  64  write data, right-justified in bit 0.
REQ-011 SHALL have port cpu_req_size  input  3  0=byte, 1=half, 2=word, 3=double.
REQ-012 SHALL have port cpu_rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port cpu_rsp_rdata  output  64  read data, right-justified, zero-extended.
REQ-014 SHALL have port cpu_rsp_err  output  1  access fault, qualified by cpu_rsp_valid.
REQ-015 SHALL have port p_req_addr  output  16  offset within selected target window.
REQ-016 SHALL have port p_req_wdata  output  64  write data, passed unchanged.
REQ-017 SHALL have port p_req_we  output  1  write enable to target.
REQ-018 SHALL have port p_req_size  output  3  access size to target.
REQ-019 SHALL have port clint_req_valid  output  1  CLINT request strobe.
REQ-020 SHALL have port clint_req_ready  input  1  CLINT completion (registered, one cycle after strobe).
REQ-021 SHALL have port clint_req_rdata  input  64  CLINT read data, full aligned 64-bit register.
REQ-022 SHALL have port uart_req_valid  output  1  UART request strobe.
REQ-023 SHALL have port uart_req_ready  input  1  UART completion.
REQ-024 SHALL have port uart_req_rdata  input  64  UART read data, byte lane 0.

Function
REQ-025 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; ERR_RESP for decode faults.
REQ-026 SHALL assert cpu_req_ready only in IDLE; handshake = cpu_req_valid & cpu_req_ready; request fields latched on handshake.
REQ-027 SHALL decode: addr in [CLINT_BASE, +0x10000) -> CLINT, offset addr[15:0]; [UART_BASE, +0x1000) -> UART, offset {4'h0, addr[11:0]}; else unmapped.
REQ-028 SHALL treat misaligned (addr & ((1<<size)-1) != 0), size > 3, or unmapped as fault: IDLE -> ERR_RESP, no target strobe.
REQ-029 SHALL assert exactly one target valid for exactly one cycle (ISSUE) per transaction, so targets that act on every valid cycle never see a duplicate write.
REQ-030 SHALL hold p_req_* stable from ISSUE until return to IDLE.
REQ-031 SHALL, in WAIT, capture selected target rdata on the cycle its ready is high and go to RESP; ready seen during ISSUE is ignored.
REQ-032 SHALL count WAIT cycles; at TIMEOUT_CYCLES without ready go to ERR_RESP; late ready in IDLE is discarded.
REQ-033 SHALL align read data: shift captured rdata right by 8*addr[2:0], then mask to 8/16/32/64 bits per size (e.g. word at offset 0xBFFC returns mtime[63:32]).
REQ-034 SHALL pulse cpu_rsp_valid for one cycle in RESP/ERR_RESP; rdata=0 on writes and on errors; err=1 only in ERR_RESP.
REQ-035 SHALL give minimum latency handshake -> cpu_rsp_valid of 3 cycles for CLINT (ISSUE, WAIT, RESP); error response 1 cycle after handshake.
REQ-036 SHALL not accept a new request until the cycle after cpu_rsp_valid (back-to-back issue rate 1 per 4 cycles).

Reset
REQ-037 SHALL on reset_n low force IDLE, counter 0, all outputs 0 (cpu_req_ready goes to 1 after reset release); in-flight transaction abandoned, no response.

Structure
REQ-038 SHALL place FSM state encoding, size codes and window sizes in a shared peripheral package; base addresses remain parameters.
REQ-039 SHALL factor read alignment/masking into sub-module periph_rdata_align (combinational, used by future bridges).

Verification
REQ-040 SHALL test: 64-bit write 0x0000_0000_0000_1234 to 0x0200_4000 -> one clint_req_valid cycle, p_req_addr=0x4000, rsp err=0 three cycles after handshake.
REQ-041 SHALL test: word read 0x0200_BFFC with clint_req_rdata=0x0000_0005_0000_0009 -> cpu_rsp_rdata=0x5.
REQ-042 SHALL test: byte read 0x1000_0005 with uart_req_rdata lane0=0xA5 -> uart strobe, p_req_addr=0x0005, rdata=0xA5.
REQ-043 SHALL test: read 0x3000_0000 and word read 0x0200_0002 -> err=1 one cycle after handshake, no target strobe.
REQ-044 SHALL test: UART ready held low -> err=1 after 16 WAIT cycles; next request accepted normally.
REQ-045 SHALL test: reset_n asserted during WAIT -> no cpu_rsp_valid, outputs 0, IDLE after release.

Source files
------------

// File: rtl/periph_bridge_pkg.sv
// Shared peripheral definitions: bridge FSM encoding, access size codes,
// target window sizes and the small helpers every bridge needs.
package periph_bridge_pkg;

   // FSM state encoding, kept as plain constants so legacy code can compare against them.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ISSUE    = 3'd1;
   localparam logic [2:0] ST_WAIT     = 3'd2;
   localparam logic [2:0] ST_RESP     = 3'd3;
   localparam logic [2:0] ST_ERR_RESP = 3'd4;

   // Access size codes as carried on cpu_req_size / p_req_size.
   typedef enum logic [2:0] {
      SIZE_B = 3'd0,
      SIZE_H = 3'd1,
      SIZE_W = 3'd2,
      SIZE_D = 3'd3
   } size_e;

   // Decoded destination of a request.
   typedef enum logic [1:0] {
      TGT_NONE  = 2'd0,
      TGT_CLINT = 2'd1,
      TGT_UART  = 2'd2
   } tgt_e;

   // Window sizes; the bases stay parameters of each bridge.
   localparam logic [31:0] CLINT_WIN_SIZE = 32'h0001_0000;
   localparam logic [31:0] UART_WIN_SIZE  = 32'h0000_1000;

   // True when the address is not naturally aligned for the size, or the size code is illegal.
   function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] size);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return addr[0];
         SIZE_W:  return |addr[1:0];
         SIZE_D:  return |addr[2:0];
         default: return 1'b1;
      endcase
   endfunction

   // Keeps the low 1/2/4/8 bytes of a right-justified value.
   function automatic logic [63:0] size_mask(input logic [2:0] size);
      case (size)
         SIZE_B:  return 64'h0000_0000_0000_00FF;
         SIZE_H:  return 64'h0000_0000_0000_FFFF;
         SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/periph_bridge_if.sv
// Bus bundles around the peripheral bridge: the CPU-facing request/response
// channel and the shared target-facing request bus with per-target strobes.
interface cpu_bus_if;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic [31:0] cpu_req_addr;
   logic        cpu_req_we;
   logic [63:0] cpu_req_wdata;
   logic [2:0]  cpu_req_size;
   logic        cpu_rsp_valid;
   logic [63:0] cpu_rsp_rdata;
   logic        cpu_rsp_err;

   // CPU side drives requests and consumes responses.
   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_size,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err
   );
   // Bridge side accepts requests and produces responses.
   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_size,
      output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err
   );
endinterface

interface periph_bus_if;
   logic [15:0] p_req_addr;
   logic [63:0] p_req_wdata;
   logic        p_req_we;
   logic [2:0]  p_req_size;
   logic        clint_req_valid;
   logic        clint_req_ready;
   logic [63:0] clint_req_rdata;
   logic        uart_req_valid;
   logic        uart_req_ready;
   logic [63:0] uart_req_rdata;

   // Bridge side drives the shared request fields and the target strobes.
   modport master (
      output p_req_addr, p_req_wdata, p_req_we, p_req_size, clint_req_valid, uart_req_valid,
      input  clint_req_ready, clint_req_rdata, uart_req_ready, uart_req_rdata
   );
   // Target side sees the requests and returns completion and data.
   modport slave (
      input  p_req_addr, p_req_wdata, p_req_we, p_req_size, clint_req_valid, uart_req_valid,
      output clint_req_ready, clint_req_rdata, uart_req_ready, uart_req_rdata
   );
endinterface

// File: rtl/periph_rdata_align.sv
// Read-data alignment: moves the addressed bytes of a 64-bit target word down
// to bit 0 and zero-extends them to the access size.
module periph_rdata_align
   import periph_bridge_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  offset_i,
   input  logic [2:0]  size_i,
   output logic [63:0] rdata_o
);

   logic [63:0] shifted;

   // Byte-offset shift followed by the size mask.
   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      rdata_o = shifted & size_mask(size_i);
   end

endmodule

// File: rtl/periph_bridge.sv
// CPU to peripheral bridge: decodes one request at a time into the CLINT or
// UART window, strobes the target for a single cycle, waits (bounded) for its
// completion and returns an aligned, single-cycle response or an access fault.
module periph_bridge
   import periph_bridge_pkg::*;
#(
   parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
   parameter logic [31:0] UART_BASE      = 32'h1000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   cpu_bus_if.slave     cpu,
   periph_bus_if.master periph
);

   localparam int unsigned          CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      rdata_q, rdata_d;
   logic             ready_q;

   tgt_e             tgt_q;
   logic             we_q;
   logic [2:0]       size_q;
   logic [2:0]       off_q;
   logic [15:0]      p_addr_q;
   logic [63:0]      p_wdata_q;

   logic [31:0]      clint_rel, uart_rel;
   tgt_e             tgt_dec;
   logic [15:0]      off_dec;
   logic             fault;
   logic             handshake;
   logic             tgt_ready;
   logic [63:0]      tgt_rdata;
   logic [2:0]       align_off;
   logic [63:0]      aligned_rdata;

   assign handshake = cpu.cpu_req_valid & ready_q;

   // Address decode of the incoming request; window membership via unsigned distance from base.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      clint_rel = cpu.cpu_req_addr - CLINT_BASE;
      uart_rel  = cpu.cpu_req_addr - UART_BASE;
      tgt_dec   = TGT_NONE;
      off_dec   = 16'h0000;
      if (clint_rel < CLINT_WIN_SIZE) begin
         tgt_dec = TGT_CLINT;
         off_dec = cpu.cpu_req_addr[15:0];
      end else if (uart_rel < UART_WIN_SIZE) begin
         tgt_dec = TGT_UART;
         off_dec = {4'h0, cpu.cpu_req_addr[11:0]};
      end
      fault = (tgt_dec == TGT_NONE) | misaligned(cpu.cpu_req_addr, cpu.cpu_req_size);
   end

   // Completion and data of whichever target the latched request selected.
   always_comb begin
      tgt_ready = 1'b0;
      tgt_rdata = 64'h0;
      case (tgt_q)
         TGT_CLINT: begin
            tgt_ready = periph.clint_req_ready;
            tgt_rdata = periph.clint_req_rdata;
         end
         TGT_UART: begin
            tgt_ready = periph.uart_req_ready;
            tgt_rdata = periph.uart_req_rdata;
         end
         default: ;
      endcase
   end

   // Transaction sequencing with the bounded wait for target completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) state_d = fault ? ST_ERR_RESP : ST_ISSUE;
         end
         ST_ISSUE: begin
            // Ready during the strobe cycle is deliberately not looked at.
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            if (tgt_ready) begin
               rdata_d = tgt_rdata;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ERR_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, wait counter, captured data and the registered accept flag.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= 64'h0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         // Registered so ready stays low while reset is held and rises on the first edge after.
         ready_q <= (state_d == ST_IDLE);
      end
   end

   // Request fields latched on the handshake and held until the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tgt_q     <= TGT_NONE;
         we_q      <= 1'b0;
         size_q    <= 3'd0;
         off_q     <= 3'd0;
         p_addr_q  <= 16'h0;
         p_wdata_q <= 64'h0;
      end else if (handshake) begin
         tgt_q     <= tgt_dec;
         we_q      <= cpu.cpu_req_we;
         size_q    <= cpu.cpu_req_size;
         off_q     <= cpu.cpu_req_addr[2:0];
         p_addr_q  <= off_dec;
         p_wdata_q <= cpu.cpu_req_wdata;
      end
   end

   // CLINT returns the whole aligned register; the UART already presents its byte in lane 0.
   assign align_off = (tgt_q == TGT_CLINT) ? off_q : 3'd0;

   periph_rdata_align u_align (
      .rdata_i  (rdata_q),
      .offset_i (align_off),
      .size_i   (size_q),
      .rdata_o  (aligned_rdata)
   );

   assign cpu.cpu_req_ready   = ready_q;
   assign cpu.cpu_rsp_valid   = (state_q == ST_RESP) | (state_q == ST_ERR_RESP);
   assign cpu.cpu_rsp_err     = (state_q == ST_ERR_RESP);
   assign cpu.cpu_rsp_rdata   = ((state_q == ST_RESP) && !we_q) ? aligned_rdata : 64'h0;

   assign periph.p_req_addr      = p_addr_q;
   assign periph.p_req_wdata     = p_wdata_q;
   assign periph.p_req_we        = we_q;
   assign periph.p_req_size      = size_q;
   assign periph.clint_req_valid = (state_q == ST_ISSUE) && (tgt_q == TGT_CLINT);
   assign periph.uart_req_valid  = (state_q == ST_ISSUE) && (tgt_q == TGT_UART);

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge: directed vector table, reset-in-flight
// sequence and randomized transactions checked against a behavioural model.
module tb_periph_bridge;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cpu_bus_if    cpu ();
   periph_bus_if per ();

   periph_bridge #(
      .CLINT_BASE     (32'h0200_0000),
      .UART_BASE      (32'h1000_0000),
      .TIMEOUT_CYCLES (16)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cpu     (cpu),
      .periph  (per)
   );

   localparam int TMO = 16;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          cyc;
      int          n_clint;
      int          n_uart;
      logic [15:0] paddr;
   } exp_t;

   typedef struct {
      int          rsp_cyc;
      int          rsp_cnt;
      logic [63:0] rdata;
      logic        err;
      int          n_clint;
      int          n_uart;
      logic [15:0] paddr;
      logic [63:0] pwdata;
      logic        pwe;
      logic [2:0]  psize;
      logic        stable;
      logic        ready_at_rsp;
      logic        ready_after;
   } obs_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [2:0]  size;
      logic [63:0] clint_rd;
      logic [63:0] uart_rd;
      int          lat;
      exp_t        exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Behavioural expectation straight from the address map and timing rules.
   function automatic exp_t model(input logic [31:0] addr, input logic we, input logic [2:0] size,
                                  input logic [63:0] clint_rd, input logic [63:0] uart_rd,
                                  input int lat);
      exp_t        e;
      bit          in_clint, in_uart, bad_align;
      int          nbytes;
      logic [63:0] src;
      logic [31:0] rel;
      e = '{err: 1'b0, rdata: 64'h0, cyc: 0, n_clint: 0, n_uart: 0, paddr: 16'h0};
      in_clint  = (addr >= 32'h0200_0000) && (addr < 32'h0201_0000);
      in_uart   = (addr >= 32'h1000_0000) && (addr < 32'h1000_1000);
      bad_align = (size > 3) || ((addr % (32'd1 << size)) != 0);
      if (!(in_clint || in_uart) || bad_align) begin
         e.err = 1'b1;
         e.cyc = 1;
         return e;
      end
      e.n_clint = in_clint ? 1 : 0;
      e.n_uart  = in_uart ? 1 : 0;
      rel       = in_clint ? addr - 32'h0200_0000 : addr - 32'h1000_0000;
      e.paddr   = rel[15:0];
      if (lat < 1 || lat > TMO) begin
         e.err = 1'b1;
         e.cyc = 2 + TMO;
         return e;
      end
      e.cyc = 1 + lat + 1;
      if (!we) begin
         nbytes  = 1 << size;
         src     = in_clint ? (clint_rd >> (8 * (addr % 8))) : uart_rd;
         e.rdata = (nbytes == 8) ? src : src % (64'd1 << (8 * nbytes));
      end
      return e;
   endfunction

   // One complete transaction; target ready pulses 'lat' cycles after the strobe (-1 = never).
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [63:0] wdata,
                          input logic [2:0] size, input logic [63:0] clint_rd,
                          input logic [63:0] uart_rd, input int lat, output obs_t o);
      int strobe_cyc;
      int guard;
      o = '{rsp_cyc: 0, rsp_cnt: 0, rdata: 64'h0, err: 1'b0, n_clint: 0, n_uart: 0,
            paddr: 16'h0, pwdata: 64'h0, pwe: 1'b0, psize: 3'd0, stable: 1'b1,
            ready_at_rsp: 1'b0, ready_after: 1'b0};
      per.clint_req_rdata = clint_rd;
      per.uart_req_rdata  = uart_rd;
      guard = 0;
      while (cpu.cpu_req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready_before_issue", cpu.cpu_req_ready, 1'b1);
      cpu.cpu_req_valid = 1'b1;
      cpu.cpu_req_addr  = addr;
      cpu.cpu_req_we    = we;
      cpu.cpu_req_wdata = wdata;
      cpu.cpu_req_size  = size;
      @(posedge clk);
      @(negedge clk);
      cpu.cpu_req_valid = 1'b0;
      strobe_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (per.clint_req_valid === 1'b1) o.n_clint++;
         if (per.uart_req_valid === 1'b1) o.n_uart++;
         if (strobe_cyc == 0 && (per.clint_req_valid === 1'b1 || per.uart_req_valid === 1'b1)) begin
            strobe_cyc = cyc;
            o.paddr  = per.p_req_addr;
            o.pwdata = per.p_req_wdata;
            o.pwe    = per.p_req_we;
            o.psize  = per.p_req_size;
         end
         if (strobe_cyc != 0 && o.rsp_cyc == 0 &&
             (per.p_req_addr !== o.paddr || per.p_req_wdata !== o.pwdata ||
              per.p_req_we !== o.pwe || per.p_req_size !== o.psize))
            o.stable = 1'b0;
         if (cpu.cpu_rsp_valid === 1'b1) begin
            o.rsp_cnt++;
            if (o.rsp_cyc == 0) begin
               o.rsp_cyc      = cyc;
               o.rdata        = cpu.cpu_rsp_rdata;
               o.err          = cpu.cpu_rsp_err;
               o.ready_at_rsp = cpu.cpu_req_ready;
            end
         end
         if (o.rsp_cyc != 0 && cyc == o.rsp_cyc + 1) o.ready_after = cpu.cpu_req_ready;
         per.clint_req_ready = (strobe_cyc != 0) && (lat >= 0) && (cyc == strobe_cyc + lat) && (o.n_clint > 0);
         per.uart_req_ready  = (strobe_cyc != 0) && (lat >= 0) && (cyc == strobe_cyc + lat) && (o.n_uart > 0);
         if (o.rsp_cyc != 0 && cyc >= o.rsp_cyc + 2) break;
         @(negedge clk);
      end
      per.clint_req_ready = 1'b0;
      per.uart_req_ready  = 1'b0;
   endtask

   task automatic compare(input string tag, input obs_t o, input exp_t e, input logic we,
                          input logic [63:0] wdata, input logic [2:0] size);
      check({tag, ".rsp_cycle"}, 64'(o.rsp_cyc), 64'(e.cyc));
      check({tag, ".rsp_count"}, 64'(o.rsp_cnt), 64'd1);
      check({tag, ".err"}, o.err, e.err);
      check({tag, ".rdata"}, o.rdata, e.rdata);
      check({tag, ".clint_strobes"}, 64'(o.n_clint), 64'(e.n_clint));
      check({tag, ".uart_strobes"}, 64'(o.n_uart), 64'(e.n_uart));
      check({tag, ".ready_at_rsp"}, o.ready_at_rsp, 1'b0);
      check({tag, ".ready_after_rsp"}, o.ready_after, 1'b1);
      if (e.n_clint + e.n_uart > 0) begin
         check({tag, ".p_addr"}, o.paddr, e.paddr);
         check({tag, ".p_wdata"}, o.pwdata, wdata);
         check({tag, ".p_we"}, o.pwe, we);
         check({tag, ".p_size"}, o.psize, size);
         check({tag, ".p_stable"}, o.stable, 1'b1);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".req_ready"}, cpu.cpu_req_ready, 1'b0);
      check({tag, ".rsp_valid"}, cpu.cpu_rsp_valid, 1'b0);
      check({tag, ".rsp_err"}, cpu.cpu_rsp_err, 1'b0);
      check({tag, ".rsp_rdata"}, cpu.cpu_rsp_rdata, 64'h0);
      check({tag, ".p_addr"}, per.p_req_addr, 16'h0);
      check({tag, ".p_wdata"}, per.p_req_wdata, 64'h0);
      check({tag, ".p_we_size"}, {per.p_req_we, per.p_req_size}, 4'h0);
      check({tag, ".strobes"}, {per.clint_req_valid, per.uart_req_valid}, 2'b00);
   endtask

   vec_t vecs[18];
   obs_t o;
   exp_t e;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rsp_seen;
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata, crd, urd;
      logic [2:0]  size;
      int          lat, sel;

      // Expected values derived by hand from the address map and timing rules.
      vecs[0]  = '{32'h0200_4000, 1'b1, 64'h0000_0000_0000_1234, 3'd3, 64'h0, 64'h0, 1,
                   '{1'b0, 64'h0, 3, 1, 0, 16'h4000}};
      vecs[1]  = '{32'h0200_BFFC, 1'b0, 64'h0, 3'd2, 64'h0000_0005_0000_0009, 64'h0, 1,
                   '{1'b0, 64'h5, 3, 1, 0, 16'hBFFC}};
      vecs[2]  = '{32'h1000_0005, 1'b0, 64'h0, 3'd0, 64'h0, 64'h1122_3344_5566_77A5, 2,
                   '{1'b0, 64'hA5, 4, 0, 1, 16'h0005}};
      vecs[3]  = '{32'h3000_0000, 1'b0, 64'h0, 3'd3, 64'h0, 64'h0, 1,
                   '{1'b1, 64'h0, 1, 0, 0, 16'h0}};
      vecs[4]  = '{32'h0200_0002, 1'b0, 64'h0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1,
                   '{1'b1, 64'h0, 1, 0, 0, 16'h0}};
      vecs[5]  = '{32'h1000_0010, 1'b0, 64'h0, 3'd2, 64'h0, 64'h0000_0000_1234_5678, -1,
                   '{1'b1, 64'h0, 18, 0, 1, 16'h0010}};
      vecs[6]  = '{32'h1000_0000, 1'b0, 64'h0, 3'd0, 64'h0, 64'h0000_0000_0000_003C, 1,
                   '{1'b0, 64'h3C, 3, 0, 1, 16'h0000}};
      vecs[7]  = '{32'h0200_FFFF, 1'b0, 64'h0, 3'd0, 64'hAB11_2233_4455_6677, 64'h0, 1,
                   '{1'b0, 64'hAB, 3, 1, 0, 16'hFFFF}};
      vecs[8]  = '{32'h0201_0000, 1'b0, 64'h0, 3'd0, 64'h0, 64'h0, 1,
                   '{1'b1, 64'h0, 1, 0, 0, 16'h0}};
      vecs[9]  = '{32'h1000_0FFF, 1'b0, 64'h0, 3'd0, 64'h0, 64'h0000_0000_0000_005A, 1,
                   '{1'b0, 64'h5A, 3, 0, 1, 16'h0FFF}};
      vecs[10] = '{32'h1000_1000, 1'b0, 64'h0, 3'd0, 64'h0, 64'h0, 1,
                   '{1'b1, 64'h0, 1, 0, 0, 16'h0}};
      vecs[11] = '{32'h0200_0000, 1'b0, 64'h0, 3'd4, 64'h0, 64'h0, 1,
                   '{1'b1, 64'h0, 1, 0, 0, 16'h0}};
      vecs[12] = '{32'h0200_0006, 1'b0, 64'h0, 3'd1, 64'hBEEF_0000_0000_0000, 64'h0, 1,
                   '{1'b0, 64'hBEEF, 3, 1, 0, 16'h0006}};
      vecs[13] = '{32'h0200_0008, 1'b0, 64'h0, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 1,
                   '{1'b0, 64'h0123_4567_89AB_CDEF, 3, 1, 0, 16'h0008}};
      vecs[14] = '{32'h0200_0000, 1'b0, 64'h0, 3'd3, 64'h1111_2222_3333_4444, 64'h0, 0,
                   '{1'b1, 64'h0, 18, 1, 0, 16'h0000}};
      vecs[15] = '{32'h1000_0001, 1'b0, 64'h0, 3'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FF77, 16,
                   '{1'b0, 64'h77, 18, 0, 1, 16'h0001}};
      vecs[16] = '{32'h1000_0008, 1'b0, 64'h0, 3'd2, 64'h0, 64'h0000_0000_0000_0042, 17,
                   '{1'b1, 64'h0, 18, 0, 1, 16'h0008}};
      vecs[17] = '{32'h1000_0004, 1'b1, 64'h0000_0000_0000_00C3, 3'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                   '{1'b0, 64'h0, 3, 0, 1, 16'h0004}};

      reset_n             = 1'b0;
      cpu.cpu_req_valid   = 1'b0;
      cpu.cpu_req_addr    = 32'h0;
      cpu.cpu_req_we      = 1'b0;
      cpu.cpu_req_wdata   = 64'h0;
      cpu.cpu_req_size    = 3'd0;
      per.clint_req_ready = 1'b0;
      per.clint_req_rdata = 64'h0;
      per.uart_req_ready  = 1'b0;
      per.uart_req_rdata  = 64'h0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset.req_ready", cpu.cpu_req_ready, 1'b1);

      // Directed vectors.
      for (int i = 0; i < 18; i++) begin
         run_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].size,
                 vecs[i].clint_rd, vecs[i].uart_rd, vecs[i].lat, o);
         compare($sformatf("vec%0d", i), o, vecs[i].exp, vecs[i].we, vecs[i].wdata, vecs[i].size);
      end

      // Reset asserted while the bridge waits on the CLINT.
      @(negedge clk);
      cpu.cpu_req_valid = 1'b1;
      cpu.cpu_req_addr  = 32'h0200_0008;
      cpu.cpu_req_we    = 1'b1;
      cpu.cpu_req_wdata = 64'h0000_0000_0000_DEAD;
      cpu.cpu_req_size  = 3'd3;
      @(posedge clk);
      @(negedge clk);
      cpu.cpu_req_valid = 1'b0;
      check("rst_wait.strobe_issue", per.clint_req_valid, 1'b1);
      @(negedge clk);
      check("rst_wait.p_we_before", per.p_req_we, 1'b1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("rst_wait");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      per.clint_req_ready = 1'b1;
      rsp_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         per.clint_req_ready = 1'b0;
         if (cpu.cpu_rsp_valid === 1'b1) rsp_seen++;
      end
      check("rst_wait.no_response", 64'(rsp_seen), 64'd0);
      check("rst_wait.idle_ready", cpu.cpu_req_ready, 1'b1);
      run_txn(32'h0200_BFFC, 1'b0, 64'h0, 3'd2, 64'h0000_0005_0000_0009, 64'h0, 1, o);
      compare("after_rst", o, model(32'h0200_BFFC, 1'b0, 3'd2, 64'h0000_0005_0000_0009, 64'h0, 1),
              1'b0, 64'h0, 3'd2);

      // Randomized traffic against the model.
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 5)      addr = 32'h0200_0000 + $urandom_range(0, 32'hFFFF);
         else if (sel < 8) addr = 32'h1000_0000 + $urandom_range(0, 32'hFFF);
         else if (sel == 8) addr = (($urandom_range(0, 1) == 0) ? 32'h0201_0000 : 32'h1000_1000)
                                   - 32'($urandom_range(0, 8));
         else              addr = $urandom;
         size = 3'($urandom_range(0, 4));
         if (size <= 3 && $urandom_range(0, 9) < 8) addr = addr & ~((32'd1 << size) - 1);
         we    = 1'($urandom_range(0, 1));
         wdata = {$urandom, $urandom};
         crd   = {$urandom, $urandom};
         urd   = {$urandom, $urandom};
         lat   = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 18));
         e     = model(addr, we, size, crd, urd, lat);
         run_txn(addr, we, wdata, size, crd, urd, lat, o);
         compare($sformatf("rnd%0d", n), o, e, we, wdata, size);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
